// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential signed shift-add multiplier.
package mult_pkg;

  localparam int MULT_N  = 8;
  localparam int MULT_RW = 14;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_e;

  // Two's complement to unsigned magnitude; the most negative value maps to 2^(N-1).
  function automatic logic [MULT_N-1:0] mag(input logic signed [MULT_N-1:0] v);
    logic signed [MULT_N-1:0] neg;
    neg = -v;
    return v[MULT_N-1] ? $unsigned(neg) : $unsigned(v);
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add multiplier datapath: accumulator, multiplier shift register and adder.
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic           clk,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [N-1:0]   mplr_i,
  input  logic [N-1:0]   mcand_i,
  output logic [2*N-1:0] product_o
);

  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] acc_d;
  logic [N-1:0]   mplr_q;
  logic [N-1:0]   mcand_q;
  logic [N:0]     sum;

  // The carry out of the upper-half add becomes the new MSB after the shift.
  always_comb begin
    sum   = {1'b0, acc_q[2*N-1:N]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {sum, acc_q[N-1:1]};
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      acc_q   <= '0;
      mplr_q  <= mplr_i;
      mcand_q <= mcand_i;
    end else if (step_i) begin
      acc_q   <= acc_d;
      mplr_q  <= mplr_q >> 1;
    end
  end

  assign product_o = acc_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for the 8x8 signed shift-add multiplier: FSM, step counter,
// sign/zero/saturation post-processing and registered result outputs.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int N  = MULT_N,
  parameter int RW = MULT_RW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [N-1:0]  multiplier,
  input  logic [N-1:0]  multiplicand,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result,
  output logic          sign,
  output logic          zflag,
  output logic          ovf
);

  localparam int CW = $clog2(N);
  localparam logic [2*N-1:0] SAT_MAX = (2*N)'((64'd1 << RW) - 64'd1);

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic           sign_tmp_q;
  logic           busy_q;
  logic           done_q;
  logic [RW-1:0]  result_q;
  logic           sign_q;
  logic           zflag_q;
  logic           ovf_q;

  logic [N-1:0]   mplr_mag;
  logic [N-1:0]   mcand_mag;
  logic           zero_op;
  logic           load;
  logic           step;
  logic [2*N-1:0] product;
  logic [RW-1:0]  result_d;
  logic           ovf_d;
  logic           zflag_d;
  logic           sign_d;

  always_comb begin
    mplr_mag  = mag(multiplier);
    mcand_mag = mag(multiplicand);
    zero_op   = (mplr_mag == '0) || (mcand_mag == '0);
    load      = (state_q == IDLE) && start;
    step      = (state_q == CALC);
  end

  mult_shift_add_dp #(
    .N (N)
  ) u_dp (
    .clk       (clk),
    .load_i    (load),
    .step_i    (step),
    .mplr_i    (mplr_mag),
    .mcand_i   (mcand_mag),
    .product_o (product)
  );

  // Saturate against the full 2N-bit product; zero products never report negative.
  always_comb begin
    ovf_d    = (product > SAT_MAX);
    result_d = ovf_d ? {RW{1'b1}} : product[RW-1:0];
    zflag_d  = (product == '0);
    sign_d   = sign_tmp_q & ~zflag_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sign_tmp_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      sign_q     <= 1'b0;
      zflag_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_tmp_q <= multiplier[N-1] ^ multiplicand[N-1];
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= zero_op ? FIN : CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_q <= FIN;
        end
        FIN: begin
          result_q <= result_d;
          ovf_q    <= ovf_d;
          zflag_q  <= zflag_d;
          sign_q   <= sign_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign sign   = sign_q;
  assign zflag  = zflag_q;
  assign ovf    = ovf_q;

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequencing controller for the 8x8 signed shift-add multiplier. It accepts a start request, captures both operands and splits them into sign and magnitude. It then runs one add-shift step per clock and applies sign, zero and saturation rules before presenting a registered result with a one-cycle done pulse. It sits between the operand source (switches or upstream logic) and the result/display logic, and owns all load, shift and add enables of the multiply datapath.

Parameters:
N, 8, operand width (two's complement)
RW, 14, result magnitude width; must satisfy RW >= 2N-2

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
multiplier  in  N  signed operand A
multiplicand  in  N  signed operand B
busy  out  1  high from accepted start until the done cycle
done  out  1  one-cycle pulse; result/sign/zflag/ovf valid and updated
result  out  RW  product magnitude, held until next done
sign  out  1  product sign (1 = negative), held
zflag  out  1  product is zero, held
ovf  out  1  magnitude exceeded 2^RW-1 and was saturated, held

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy, done, result, sign, zflag, ovf all 0; counter 0. Effective immediately, including mid-operation. The operation in flight is discarded with no done.
- States: IDLE, CALC, FIN.
- IDLE: if start=1 at edge E0:
  - capture |multiplier| and |multiplicand| as (N)-bit unsigned magnitudes; -2^(N-1) maps to magnitude 2^(N-1).
  - capture sign_tmp = msbA ^ msbB; clear the 2N-bit accumulator; step counter=0; busy=1.
  - if either magnitude is 0, go to FIN; else go to CALC.
- CALC: each edge performs one step:
  - if multiplier-magnitude LSB=1, add multiplicand magnitude to the upper half of the accumulator;
  - then shift the accumulator/multiplier pair right by 1 and increment the counter.
  - After step N (counter==N-1 at the edge), go to FIN. Exactly N CALC edges (E1..E8 for N=8).
- FIN (one edge, E9 for the normal path, E1 for the zero-operand path):
  - result = min(product, 2^RW-1); ovf = (product > 2^RW-1).
  - zflag = (product==0); sign = sign_tmp & ~zflag (no negative zero).
  - done=1 for exactly that one following cycle; busy=0; state=IDLE.
- Latency: done is high in the cycle after E9 (9 edges after the accepting edge) for nonzero operands, and after E1 for zero operands.
- start while busy: ignored. Operand changes while busy have no effect.
- start=1 during the done cycle: state is IDLE, so it is accepted (back-to-back throughput of 10 cycles per product).
- done is never high while busy is high. result/sign/zflag/ovf change only on the edge that raises done.
- Widths: the accumulator is 2N bits unsigned. Saturation compares the full 2N-bit product against 2^RW-1.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, CALC, FIN};
  - constants MULT_N=8, MULT_RW=14;
  - a magnitude function (two's complement to unsigned N-bit).
- One sub-module, mult_shift_add_dp: holds the accumulator, multiplier shift register and adder. It is driven by load/step enables from the controller FSM and exposes the 2N-bit product. The FSM, counter, sign/zero/saturation logic and output registers stay in mult_seq_ctrl.

Test Plan:
1. multiplier=3, multiplicand=10, start pulse -> done 9 edges later; result=30, sign=0, zflag=0, ovf=0; busy high for exactly 9 cycles.
2. multiplier=-5 (8'hFB), multiplicand=7 -> result=35, sign=1. Then multiplier=-12, multiplicand=-11 -> result=132, sign=0.
3. multiplier=0, multiplicand=-9 -> done 1 edge after accept; result=0, zflag=1, sign=0, ovf=0.
4. multiplier=-128, multiplicand=-128 -> result=16383, ovf=1, sign=0. Then -128 x 127 -> result=16256, ovf=0, sign=1.
5. start held high throughout busy with operands changed mid-CALC -> first product unaffected. A second operation starts on the done-cycle edge and its done arrives 9 edges later with the new operands.
6. reset_n driven low at CALC step 4 -> busy, done, result, sign, zflag, ovf read 0 immediately; no done after release. A new start after release produces a correct result.
